main_host_driver: RTL and testbench

MAIN_HOST_DRIVER -- requirements
Module: main_host_driver

---
 rtl/main_host_pkg.sv | 43 ++++
 rtl/host_cycle_counter.sv | 57 +++++
 rtl/main_host_driver.sv | 263 ++++++++++++++++++++++++++
 tb/tb_main_host_driver.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_host_pkg.sv
// -----------------------------------------------------------------------------
// main_host_pkg
//   Shared definitions for the host-side driver: command opcodes, the driver
//   state enumeration, default parameter values and fixed field widths.
//   Imported by main_host_driver and host_cycle_counter.
// -----------------------------------------------------------------------------
package main_host_pkg;

    // Default parameter values for the top level.
    localparam int unsigned DEF_ADDR_W      = 10;
    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_RUN_TIMEOUT = 200_000_000;
    localparam int unsigned DEF_MEM_TIMEOUT = 16;

    // Fixed widths.
    localparam int unsigned SIZE_W = 6;   // per-channel access size field
    localparam int unsigned CNT_W  = 32;  // cycle counter / rsp_cycles width
    localparam int unsigned N_CHAN = 2;   // slave channels on the memory port

    // Command opcodes carried on cmd_op.
    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_RUN   = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    // Driver FSM states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR        = 3'd1,
        RD        = 3'd2,
        START     = 3'd3,
        WAIT_DONE = 3'd4,
        RSP       = 3'd5
    } state_e;

    // True in the states that hold a memory access open on channel 0.
    function automatic logic is_mem_state(input state_e s);
        return (s == WR) || (s == RD);
    endfunction

endpackage : main_host_pkg

// File: rtl/host_cycle_counter.sv
// -----------------------------------------------------------------------------
// host_cycle_counter
//   Saturating cycle counter with clear, enable and compare-to-limit. Used by
//   the host driver both as the memory-access timeout and as the accelerator
//   run-latency counter.
//
//   A clear restarts the count; if enable is also high in that cycle, the
//   clearing cycle itself is counted, so count_o reads 1 in the first cycle
//   after an enabled clear. The count sticks at all-ones instead of wrapping.
//
// Ports
//   clock       in   clock
//   reset       in   synchronous active-high reset (count -> 0)
//   clear_i     in   restart the count
//   enable_i    in   count this cycle
//   limit_i     in   compare value
//   count_o     out  current count
//   at_limit_o  out  count_o >= limit_i
// -----------------------------------------------------------------------------
module host_cycle_counter
    import main_host_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] count_o,
    output logic             at_limit_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {{(WIDTH-1){1'b0}}, enable_i};
        end else if (enable_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o    = count_q;
    assign at_limit_o = (count_q >= limit_i);

endmodule : host_cycle_counter

// File: rtl/main_host_driver.sv
// -----------------------------------------------------------------------------
// main_host_driver
//   Host-side command driver. Accepts WRITE / READ / RUN commands, performs the
//   access on channel 0 of a two-channel slave memory port or kicks an
//   accelerator and measures its latency, then returns one response.
//   Memory accesses are bounded by MEM_TIMEOUT cycles, accelerator runs by
//   RUN_TIMEOUT cycles; both expiries report rsp_err. Channel 1 of the slave
//   port is never used and its outputs stay at zero.
//
// Ports
//   clock, reset            clock; synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (ready only in IDLE)
//   cmd_op                  0 WRITE, 1 READ, 2 RUN, 3 reserved
//   cmd_addr/data/size      slave byte address, write data, size in bits
//   rsp_valid/rsp_ready     response handshake
//   rsp_data                read data, or return_port for RUN
//   rsp_err                 timeout or reserved op
//   rsp_cycles              RUN latency in cycles, 0 for other ops
//   start_port              one-cycle accelerator start pulse
//   done_port, return_port  accelerator completion and result
//   S_oe_ram, S_we_ram      per-channel read / write enables
//   S_addr_ram, S_Wdata_ram per-channel address / write data
//   S_data_ram_size         per-channel access size
//   Sout_Rdata_ram          per-channel read data
//   Sout_DataRdy            per-channel access acknowledge
// -----------------------------------------------------------------------------
module main_host_driver
    import main_host_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned RUN_TIMEOUT = DEF_RUN_TIMEOUT,
    parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic                       clock,
    input  logic                       reset,

    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [ADDR_W-1:0]          cmd_addr,
    input  logic [DATA_W-1:0]          cmd_data,
    input  logic [SIZE_W-1:0]          cmd_size,

    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_err,
    output logic [CNT_W-1:0]           rsp_cycles,

    output logic                       start_port,
    input  logic                       done_port,
    input  logic [31:0]                return_port,

    output logic [N_CHAN-1:0]          S_oe_ram,
    output logic [N_CHAN-1:0]          S_we_ram,
    output logic [N_CHAN*ADDR_W-1:0]   S_addr_ram,
    output logic [N_CHAN*DATA_W-1:0]   S_Wdata_ram,
    output logic [N_CHAN*SIZE_W-1:0]   S_data_ram_size,
    input  logic [N_CHAN*DATA_W-1:0]   Sout_Rdata_ram,
    input  logic [N_CHAN-1:0]          Sout_DataRdy
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e              state_q,      state_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;
    logic [DATA_W-1:0]   wdata_q,      wdata_d;
    logic [SIZE_W-1:0]   size_q,       size_d;
    logic [DATA_W-1:0]   rsp_data_q,   rsp_data_d;
    logic                rsp_err_q,    rsp_err_d;
    logic [CNT_W-1:0]    rsp_cycles_q, rsp_cycles_d;

    // Counter control
    logic                cnt_clear;
    logic                cnt_enable;
    logic [CNT_W-1:0]    cnt_limit;
    logic [CNT_W-1:0]    cnt_value;
    logic                cnt_at_limit;

    logic                mem_ack;

    // Channel 1 is never used; fold its inputs into one deliberately unused net.
    logic                unused_inputs;
    assign unused_inputs = ^{Sout_Rdata_ram[N_CHAN*DATA_W-1:DATA_W], Sout_DataRdy[1]};

    assign mem_ack = Sout_DataRdy[0];

    // -------------------------------------------------------------------------
    // Shared timeout / latency counter. Cleared and enabled together on command
    // acceptance, so it reads 1 in the first cycle of WR, RD or START and
    // equals the cycle index within the operation from then on.
    // -------------------------------------------------------------------------
    host_cycle_counter #(
        .WIDTH (CNT_W)
    ) u_cycle_counter (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (cnt_clear),
        .enable_i   (cnt_enable),
        .limit_i    (cnt_limit),
        .count_o    (cnt_value),
        .at_limit_o (cnt_at_limit)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets its default first, so no path through
        // the case leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        rsp_cycles_d = rsp_cycles_q;
        cnt_clear    = 1'b0;
        cnt_enable   = 1'b0;
        cnt_limit    = is_mem_state(state_q) ? CNT_W'(MEM_TIMEOUT) : CNT_W'(RUN_TIMEOUT);

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d       = cmd_addr;
                    wdata_d      = cmd_data;
                    size_d       = cmd_size;
                    rsp_data_d   = '0;
                    rsp_err_d    = 1'b0;
                    rsp_cycles_d = '0;
                    cnt_clear    = 1'b1;
                    cnt_enable   = 1'b1;
                    case (op_e'(cmd_op))
                        OP_WRITE: state_d = WR;
                        OP_READ:  state_d = RD;
                        OP_RUN:   state_d = START;
                        default: begin
                            state_d   = RSP;
                            rsp_err_d = 1'b1;
                        end
                    endcase
                end
            end

            WR, RD: begin
                cnt_enable = 1'b1;
                // An acknowledge in the last allowed cycle still wins over the timeout.
                if (mem_ack) begin
                    state_d = RSP;
                    if (state_q == RD) begin
                        rsp_data_d = Sout_Rdata_ram[DATA_W-1:0];
                    end
                end else if (cnt_at_limit) begin
                    state_d   = RSP;
                    rsp_err_d = 1'b1;
                end
            end

            START: begin
                cnt_enable = 1'b1;
                // A completion already present in the start cycle is honoured.
                if (done_port) begin
                    state_d      = RSP;
                    rsp_data_d   = DATA_W'(return_port);
                    rsp_cycles_d = cnt_value;
                end else begin
                    state_d = WAIT_DONE;
                end
            end

            WAIT_DONE: begin
                cnt_enable = 1'b1;
                if (done_port) begin
                    state_d      = RSP;
                    rsp_data_d   = DATA_W'(return_port);
                    rsp_cycles_d = cnt_value;
                end else if (cnt_at_limit) begin
                    state_d      = RSP;
                    rsp_err_d    = 1'b1;
                    rsp_cycles_d = CNT_W'(RUN_TIMEOUT);
                end
            end

            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the values from before this edge; reset is synchronous.
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            rsp_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            rsp_cycles_q <= rsp_cycles_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Decoded from state, and forced low while reset is high so the
    // interface is quiet even in the first reset cycle, before state_q has
    // been reloaded.
    // -------------------------------------------------------------------------
    always_comb begin
        cmd_ready       = 1'b0;
        rsp_valid       = 1'b0;
        rsp_data        = '0;
        rsp_err         = 1'b0;
        rsp_cycles      = '0;
        start_port      = 1'b0;
        S_oe_ram        = '0;
        S_we_ram        = '0;
        S_addr_ram      = '0;
        S_Wdata_ram     = '0;
        S_data_ram_size = '0;

        if (!reset) begin
            cmd_ready   = (state_q == IDLE);
            start_port  = (state_q == START);
            // WR and RD are exclusive states, so the enables can never overlap.
            S_we_ram[0] = (state_q == WR);
            S_oe_ram[0] = (state_q == RD);

            if (is_mem_state(state_q)) begin
                S_addr_ram[ADDR_W-1:0]      = addr_q;
                S_data_ram_size[SIZE_W-1:0] = size_q;
            end
            if (state_q == WR) begin
                S_Wdata_ram[DATA_W-1:0] = wdata_q;
            end

            if (state_q == RSP) begin
                rsp_valid  = 1'b1;
                rsp_data   = rsp_data_q;
                rsp_err    = rsp_err_q;
                rsp_cycles = rsp_cycles_q;
            end
        end
    end

endmodule : main_host_driver

// File: tb/tb_main_host_driver.sv
// -----------------------------------------------------------------------------
// tb_main_host_driver
//   Self-checking bench for main_host_driver. A slave memory and an
//   accelerator are modelled behaviourally; each command's expected response
//   is derived from its latency and a reference copy of memory contents.
// -----------------------------------------------------------------------------
module tb_main_host_driver;

    localparam int ADDR_W      = 10;
    localparam int DATA_W      = 32;
    localparam int RUN_TIMEOUT = 100;
    localparam int MEM_TIMEOUT = 16;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [1:0]          cmd_op = 2'd0;
    logic [ADDR_W-1:0]   cmd_addr = '0;
    logic [DATA_W-1:0]   cmd_data = '0;
    logic [5:0]          cmd_size = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_err;
    logic [31:0]         rsp_cycles;
    logic                start_port;
    logic                done_port = 1'b0;
    logic [31:0]         return_port = '0;
    logic [1:0]          S_oe_ram;
    logic [1:0]          S_we_ram;
    logic [2*ADDR_W-1:0] S_addr_ram;
    logic [2*DATA_W-1:0] S_Wdata_ram;
    logic [11:0]         S_data_ram_size;
    logic [2*DATA_W-1:0] Sout_Rdata_ram = '0;
    logic [1:0]          Sout_DataRdy = '0;

    always #5 clock = ~clock;

    main_host_driver #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .RUN_TIMEOUT (RUN_TIMEOUT),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_addr        (cmd_addr),
        .cmd_data        (cmd_data),
        .cmd_size        (cmd_size),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_err         (rsp_err),
        .rsp_cycles      (rsp_cycles),
        .start_port      (start_port),
        .done_port       (done_port),
        .return_port     (return_port),
        .S_oe_ram        (S_oe_ram),
        .S_we_ram        (S_we_ram),
        .S_addr_ram      (S_addr_ram),
        .S_Wdata_ram     (S_Wdata_ram),
        .S_data_ram_size (S_data_ram_size),
        .Sout_Rdata_ram  (Sout_Rdata_ram),
        .Sout_DataRdy    (Sout_DataRdy)
    );

    int n_checks   = 0;
    int n_fail     = 0;
    int proto_viol = 0;

    logic [31:0] slave_mem [0:1023];  // contents held by the slave model
    logic [31:0] ref_mem   [0:1023];  // contents the reference model expects

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Channel 0 enables never overlap; channel 1 stays silent.
    always @(negedge clock) begin
        if (S_we_ram[0] && S_oe_ram[0]) proto_viol++;
        if (S_we_ram[1] || S_oe_ram[1] ||
            (S_addr_ram[2*ADDR_W-1:ADDR_W] !== '0) ||
            (S_Wdata_ram[2*DATA_W-1:DATA_W] !== '0) ||
            (S_data_ram_size[11:6] !== '0)) proto_viol++;
    end

    function automatic logic any_output();
        return cmd_ready | rsp_valid | rsp_err | start_port | (|rsp_data) | (|rsp_cycles) |
               (|S_oe_ram) | (|S_we_ram) | (|S_addr_ram) | (|S_Wdata_ram) | (|S_data_ram_size);
    endfunction

    // One complete command. lat is the slave ack latency in enabled cycles for
    // WRITE/READ, or the run-cycle index of done_port for RUN; 0 means never.
    // bp is the number of cycles the response is back-pressured.
    task automatic run_txn(input logic [1:0] op, input logic [9:0] addr, input logic [31:0] data,
                           input logic [5:0] size, input int lat, input logic [31:0] ret, input int bp);
        logic        exp_err;
        logic [31:0] exp_data;
        logic [31:0] exp_cycles;
        int          exp_en;
        int          en_cycles;
        int          start_cycles;
        int          run_idx;
        bit          got_rsp;
        bit          stable;
        bit          hold_ok;
        logic [31:0] r_data;
        logic        r_err;
        logic [31:0] r_cycles;

        // Reference expectations.
        exp_data   = 32'd0;
        exp_cycles = 32'd0;
        exp_en     = 0;
        case (op)
            2'd0, 2'd1: begin
                exp_err = (lat == 0) || (lat > MEM_TIMEOUT);
                exp_en  = exp_err ? MEM_TIMEOUT : lat;
                if (op == 2'd1) exp_data = ref_mem[addr];
            end
            2'd2: begin
                exp_err    = (lat == 0) || (lat > RUN_TIMEOUT);
                exp_cycles = exp_err ? RUN_TIMEOUT : lat;
                exp_data   = ret;
            end
            default: exp_err = 1'b1;
        endcase

        check("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_size  = size;
        done_port = 1'b0;
        @(negedge clock);
        cmd_valid = 1'b0;

        en_cycles    = 0;
        start_cycles = 0;
        run_idx      = 0;
        got_rsp      = 0;
        stable       = 1;
        for (int cyc = 0; cyc < 400 && !got_rsp; cyc++) begin
            Sout_DataRdy = 2'b00;
            done_port    = 1'b0;
            if (rsp_valid) begin
                got_rsp = 1;
            end else begin
                if (S_we_ram[0] || S_oe_ram[0]) begin
                    en_cycles++;
                    if ((S_addr_ram[9:0] !== addr) || (S_data_ram_size[5:0] !== size) ||
                        (S_we_ram[0] && (S_Wdata_ram[31:0] !== data))) stable = 0;
                    if (en_cycles == lat) begin
                        Sout_DataRdy = 2'b01;
                        if (S_we_ram[0]) slave_mem[S_addr_ram[9:0]] = S_Wdata_ram[31:0];
                        Sout_Rdata_ram = {$urandom, slave_mem[S_addr_ram[9:0]]};
                    end
                end
                if (start_port) start_cycles++;
                if (start_port || run_idx > 0) run_idx++;
                if (run_idx > 0 && run_idx == lat) begin
                    done_port   = 1'b1;
                    return_port = ret;
                end
                @(negedge clock);
            end
        end
        Sout_DataRdy = 2'b00;
        done_port    = 1'b0;

        check("rsp_arrived", got_rsp, 1'b1);
        if (!got_rsp) return;

        r_data   = rsp_data;
        r_err    = rsp_err;
        r_cycles = rsp_cycles;
        check("rsp_err", r_err, exp_err);
        check("rsp_cycles", r_cycles, exp_cycles);
        if (!exp_err) check("rsp_data", r_data, exp_data);
        check("enable_cycles", en_cycles, exp_en);
        check("start_cycles", start_cycles, (op == 2'd2) ? 1 : 0);
        check("mem_fields_stable", stable, 1'b1);
        check("cmd_ready_in_rsp", cmd_ready, 1'b0);
        check("protocol", proto_viol, 0);
        if (op == 2'd0 && !exp_err) ref_mem[addr] = data;

        hold_ok = 1;
        for (int i = 0; i < bp; i++) begin
            done_port = 1'($urandom_range(0, 1));
            @(negedge clock);
            if (!rsp_valid || cmd_ready || rsp_data !== r_data || rsp_err !== r_err ||
                rsp_cycles !== r_cycles) hold_ok = 0;
        end
        done_port = 1'b0;
        if (bp > 0) check("rsp_held", hold_ok, 1'b1);
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        check("rsp_released", rsp_valid, 1'b0);
        check("cmd_ready_back", cmd_ready, 1'b1);
    endtask

    initial begin
        logic [1:0]  op;
        logic [9:0]  addr;
        logic [5:0]  size;
        int          lat;
        int          pick;
        bit          quiet;

        for (int i = 0; i < 1024; i++) begin
            slave_mem[i] = $urandom;
            ref_mem[i]   = slave_mem[i];
        end

        // Reset: everything quiet, then ready in the first cycle after release.
        repeat (3) @(negedge clock);
        check("reset_outputs_zero", any_output(), 1'b0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", cmd_ready, 1'b1);
        check("no_rsp_after_reset", rsp_valid, 1'b0);

        // Write then read back.
        run_txn(2'd0, 10'h010, 32'hDEADBEEF, 6'd32, 1, 32'd0, 0);
        run_txn(2'd1, 10'h010, 32'd0, 6'd32, 2, 32'd0, 0);
        // Run with done at cycle 37, and done already in the start cycle.
        run_txn(2'd2, 10'h000, 32'd0, 6'd0, 37, 32'd5, 0);
        run_txn(2'd2, 10'h000, 32'd0, 6'd0, 1, 32'h1234_5678, 0);
        // Memory timeout boundaries.
        run_txn(2'd1, 10'h020, 32'd0, 6'd16, 0, 32'd0, 0);
        run_txn(2'd0, 10'h024, 32'hCAFE_0001, 6'd8, MEM_TIMEOUT, 32'd0, 0);
        run_txn(2'd0, 10'h028, 32'hCAFE_0002, 6'd32, MEM_TIMEOUT + 1, 32'd0, 0);
        // Run timeout boundaries.
        run_txn(2'd2, 10'h000, 32'd0, 6'd0, 0, 32'd0, 0);
        run_txn(2'd2, 10'h000, 32'd0, 6'd0, RUN_TIMEOUT, 32'hABCD, 0);
        run_txn(2'd2, 10'h000, 32'd0, 6'd0, RUN_TIMEOUT + 1, 32'hABCD, 0);
        // Reserved op and response backpressure.
        run_txn(2'd3, 10'h000, 32'd0, 6'd0, 0, 32'd0, 2);
        run_txn(2'd1, 10'h024, 32'd0, 6'd8, 3, 32'd0, 5);

        // Randomized mix, with stray done pulses while idle.
        for (int t = 0; t < 40; t++) begin
            pick = $urandom_range(0, 9);
            op   = (pick < 4) ? 2'd0 : (pick < 7) ? 2'd1 : (pick < 9) ? 2'd2 : 2'd3;
            addr = 10'($urandom_range(0, 15) * 4);
            case ($urandom_range(0, 2))
                0:       size = 6'd8;
                1:       size = 6'd16;
                default: size = 6'd32;
            endcase
            if (op == 2'd2) lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 110);
            else            lat = $urandom_range(0, 20);
            repeat ($urandom_range(0, 2)) begin
                done_port = 1'($urandom_range(0, 1));
                @(negedge clock);
            end
            done_port = 1'b0;
            run_txn(op, addr, $urandom, size, lat, $urandom, $urandom_range(0, 3));
        end

        // Reset while waiting for the accelerator: aborted, no response.
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (10) @(negedge clock);
        check("waiting_no_rsp", rsp_valid, 1'b0);
        reset = 1'b1;
        #1;
        check("reset_mid_run_zero", any_output(), 1'b0);
        @(negedge clock);
        check("reset_next_cycle_zero", any_output(), 1'b0);
        reset = 1'b0;
        #1;
        check("ready_after_abort", cmd_ready, 1'b1);
        quiet = 1;
        for (int i = 0; i < 5; i++) begin
            done_port = (i == 1);
            @(negedge clock);
            if (rsp_valid || !cmd_ready || start_port) quiet = 0;
        end
        done_port = 1'b0;
        check("idle_after_abort", quiet, 1'b1);

        // Still functional after the abort.
        run_txn(2'd1, 10'h010, 32'd0, 6'd32, 4, 32'd0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_main_host_driver
